// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the pixel-generation stage.
package vga_pkg;

  localparam int unsigned H_DISPLAY = 800;
  localparam int unsigned V_DISPLAY = 600;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {FWD, REV} dir_t;

endpackage

// File: rtl/bounce_axis.sv
// One axis of box motion: ping-pongs pos between 0 and MAX in STEP increments.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned MAX   = 768,
  parameter int unsigned STEP  = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             en,
  output logic [WIDTH-1:0] pos,
  output dir_t             dir,
  output logic             bounce
);

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic hit_hi;
  logic hit_lo;

  // WIDTH leaves one spare bit above the display range, so pos+STEP never wraps.
  assign hit_hi = (pos + STEP_W) >= MAX_W;
  assign hit_lo = pos <= STEP_W;
  assign bounce = en & ((dir == FWD) ? hit_hi : hit_lo);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pos <= '0;
      dir <= FWD;
    end else if (en) begin
      case (dir)
        FWD: begin
          if (hit_hi) begin
            pos <= MAX_W;
            dir <= REV;
          end else begin
            pos <= pos + STEP_W;
          end
        end
        REV: begin
          if (hit_lo) begin
            pos <= '0;
            dir <= FWD;
          end else begin
            pos <= pos - STEP_W;
          end
        end
        default: dir <= FWD;
      endcase
    end
  end

endmodule

// File: rtl/bouncing_box_renderer.sv
// Draws a bouncing solid square behind the VGA timing controller; 2-cycle
// pixel pipeline keeps RGB aligned with the delayed sync/blank outputs.
module bouncing_box_renderer #(
  parameter int unsigned H_DISPLAY  = vga_pkg::H_DISPLAY,
  parameter int unsigned V_DISPLAY  = vga_pkg::V_DISPLAY,
  parameter int unsigned BOX_SIZE   = 32,
  parameter int unsigned STEP       = 2,
  parameter logic [23:0] BOX_COLOUR = 24'hFF_FF_00,
  parameter logic [23:0] BG_COLOUR  = 24'h00_00_80
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        blank_n_in,
  input  logic        hSync_n_in,
  input  logic        vSync_n_in,
  input  logic [10:0] nextX,
  input  logic [9:0]  nextY,
  input  logic        Pause,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        blank_n,
  output logic        hSync_n,
  output logic        vSync_n,
  output logic        frameTick,
  output logic [7:0]  bounceCount
);

  import vga_pkg::*;

  localparam int unsigned MAX_X = H_DISPLAY - BOX_SIZE;
  localparam int unsigned MAX_Y = V_DISPLAY - BOX_SIZE;

  logic        v_sync_prev;
  logic        tick;
  logic        axis_en;
  logic [11:0] box_x;
  logic [10:0] box_y;
  dir_t        dir_x;
  dir_t        dir_y;
  logic        bounce_x;
  logic        bounce_y;
  logic [1:0]  unused_dirs;

  // Falling edge of vSync sits inside vertical blanking, so moving here is tear-free.
  assign tick    = v_sync_prev & ~vSync_n_in;
  assign axis_en = tick & ~Pause;
  assign unused_dirs = {dir_x, dir_y};

  bounce_axis #(.WIDTH(12), .MAX(MAX_X), .STEP(STEP)) u_axis_x (
    .Clock  (Clock),
    .Reset  (Reset),
    .en     (axis_en),
    .pos    (box_x),
    .dir    (dir_x),
    .bounce (bounce_x)
  );

  bounce_axis #(.WIDTH(11), .MAX(MAX_Y), .STEP(STEP)) u_axis_y (
    .Clock  (Clock),
    .Reset  (Reset),
    .en     (axis_en),
    .pos    (box_y),
    .dir    (dir_y),
    .bounce (bounce_y)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      v_sync_prev <= 1'b1;
      frameTick   <= 1'b0;
      bounceCount <= '0;
    end else begin
      v_sync_prev <= vSync_n_in;
      frameTick   <= tick;
      bounceCount <= bounceCount + 8'(bounce_x) + 8'(bounce_y);
    end
  end

  logic [11:0] px;
  logic [10:0] py;
  logic        in_box;
  logic        blank_d1;
  logic        hs_d1;
  logic        vs_d1;
  logic        in_box_d1;

  assign px = {1'b0, nextX};
  assign py = {1'b0, nextY};
  assign in_box = (px >= box_x) && (px < box_x + 12'(BOX_SIZE)) &&
                  (py >= box_y) && (py < box_y + 11'(BOX_SIZE));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      blank_d1  <= 1'b0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
      in_box_d1 <= 1'b0;
    end else begin
      blank_d1  <= blank_n_in;
      hs_d1     <= hSync_n_in;
      vs_d1     <= vSync_n_in;
      in_box_d1 <= in_box;
    end
  end

  rgb_t pix_next;
  rgb_t rgb_q;

  always_comb begin
    pix_next = '0;
    if (blank_d1) begin
      pix_next = in_box_d1 ? rgb_t'(BOX_COLOUR) : rgb_t'(BG_COLOUR);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rgb_q   <= '0;
      blank_n <= 1'b0;
      hSync_n <= 1'b1;
      vSync_n <= 1'b1;
    end else begin
      rgb_q   <= pix_next;
      blank_n <= blank_d1;
      hSync_n <= hs_d1;
      vSync_n <= vs_d1;
    end
  end

  assign Red   = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue  = rgb_q.b;

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// Scoreboard bench: stimulus pushes expected tick/pixel results, monitors pop and compare.
module tb_bouncing_box_renderer;
  import vga_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        blank_n_in = 1'b0;
  logic        hSync_n_in = 1'b1;
  logic [10:0] nextX = '0;
  logic [9:0]  nextY = '0;
  logic        Pause = 1'b0;
  logic        vs_a = 1'b1, vs_b = 1'b1, vs_c = 1'b1;

  logic [7:0] red_a, green_a, blue_a, cnt_a;
  logic       blank_a, hs_a, vso_a, ft_a;
  logic [7:0] red_b, green_b, blue_b, cnt_b;
  logic       blank_b, hs_b, vso_b, ft_b;
  logic [7:0] red_c, green_c, blue_c, cnt_c;
  logic       blank_c, hs_c, vso_c, ft_c;

  always #5 Clock = ~Clock;

  bouncing_box_renderer dut_a (
    .Clock(Clock), .Reset(Reset), .blank_n_in(blank_n_in), .hSync_n_in(hSync_n_in),
    .vSync_n_in(vs_a), .nextX(nextX), .nextY(nextY), .Pause(Pause),
    .Red(red_a), .Green(green_a), .Blue(blue_a), .blank_n(blank_a), .hSync_n(hs_a),
    .vSync_n(vso_a), .frameTick(ft_a), .bounceCount(cnt_a));

  bouncing_box_renderer #(.V_DISPLAY(1000), .STEP(5)) dut_b (
    .Clock(Clock), .Reset(Reset), .blank_n_in(blank_n_in), .hSync_n_in(hSync_n_in),
    .vSync_n_in(vs_b), .nextX(nextX), .nextY(nextY), .Pause(Pause),
    .Red(red_b), .Green(green_b), .Blue(blue_b), .blank_n(blank_b), .hSync_n(hs_b),
    .vSync_n(vso_b), .frameTick(ft_b), .bounceCount(cnt_b));

  bouncing_box_renderer #(.H_DISPLAY(64), .V_DISPLAY(64), .BOX_SIZE(32), .STEP(4)) dut_c (
    .Clock(Clock), .Reset(Reset), .blank_n_in(blank_n_in), .hSync_n_in(hSync_n_in),
    .vSync_n_in(vs_c), .nextX(nextX), .nextY(nextY), .Pause(Pause),
    .Red(red_c), .Green(green_c), .Blue(blue_c), .blank_n(blank_c), .hSync_n(hs_c),
    .vSync_n(vso_c), .frameTick(ft_c), .bounceCount(cnt_c));

  typedef struct {
    int   due;
    int   x;
    int   y;
    dir_t dx;
    dir_t dy;
    int   cnt;
  } tick_exp_t;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic [2:0]  sync;
  } pix_exp_t;

  tick_exp_t tq_a[$];
  tick_exp_t tq_b[$];
  tick_exp_t tq_c[$];
  pix_exp_t  pq[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) cycle=%0d",
               name, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic void cmp_tick(input string tag, input tick_exp_t e, input int x,
                                   input int y, input dir_t dx, input dir_t dy, input int cnt);
    chk({tag, "_tick_latency"}, cyc, e.due);
    chk({tag, "_box_x"}, x, e.x);
    chk({tag, "_box_y"}, y, e.y);
    chk({tag, "_dir_x"}, int'(dx), int'(e.dx));
    chk({tag, "_dir_y"}, int'(dy), int'(e.dy));
    chk({tag, "_bounce_count"}, cnt, e.cnt);
  endfunction

  // Tick monitors: each frameTick must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    tick_exp_t e;
    if (ft_a) begin
      if (tq_a.size() == 0) chk("a_spurious_tick", 1, 0);
      else begin
        e = tq_a.pop_front();
        cmp_tick("a", e, int'(dut_a.box_x), int'(dut_a.box_y), dut_a.dir_x, dut_a.dir_y, int'(cnt_a));
      end
    end
    if (ft_b) begin
      if (tq_b.size() == 0) chk("b_spurious_tick", 1, 0);
      else begin
        e = tq_b.pop_front();
        cmp_tick("b", e, int'(dut_b.box_x), int'(dut_b.box_y), dut_b.dir_x, dut_b.dir_y, int'(cnt_b));
      end
    end
    if (ft_c) begin
      if (tq_c.size() == 0) chk("c_spurious_tick", 1, 0);
      else begin
        e = tq_c.pop_front();
        cmp_tick("c", e, int'(dut_c.box_x), int'(dut_c.box_y), dut_c.dir_x, dut_c.dir_y, int'(cnt_c));
      end
    end
  end

  // Pixel monitor for dut_a: colour plus {blank_n, hSync_n, vSync_n}.
  always @(negedge Clock) begin
    pix_exp_t p;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      p = pq.pop_front();
      chk("pix_due", cyc, p.due);
      chk("pix_rgb", int'({red_a, green_a, blue_a}), int'(p.rgb));
      chk("pix_sync", int'({blank_a, hs_a, vso_a}), int'(p.sync));
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic tick(input int which, input int x, input int y, input dir_t dx,
                      input dir_t dy, input int cnt, input int low_cycles);
    tick_exp_t e;
    step();
    e = '{cyc + 1, x, y, dx, dy, cnt};
    case (which)
      0: begin vs_a = 1'b0; tq_a.push_back(e); end
      1: begin vs_b = 1'b0; tq_b.push_back(e); end
      default: begin vs_c = 1'b0; tq_c.push_back(e); end
    endcase
    repeat (low_cycles) step();
    vs_a = 1'b1;
    vs_b = 1'b1;
    vs_c = 1'b1;
    repeat (2) step();
  endtask

  task automatic pix(input int x, input int y, input logic b, input logic h,
                     input logic [23:0] exp);
    step();
    nextX = 11'(x);
    nextY = 10'(y);
    blank_n_in = b;
    hSync_n_in = h;
    pq.push_back('{cyc + 2, exp, {b, h, 1'b1}});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rgb"}, int'({red_a, green_a, blue_a}), 0);
    chk({tag, "_blank_n"}, int'(blank_a), 0);
    chk({tag, "_hsync_n"}, int'(hs_a), 1);
    chk({tag, "_vsync_n"}, int'(vso_a), 1);
    chk({tag, "_frame_tick"}, int'(ft_a), 0);
    chk({tag, "_bounce_count"}, int'(cnt_a), 0);
    chk({tag, "_box_x"}, int'(dut_a.box_x), 0);
    chk({tag, "_box_y"}, int'(dut_a.box_y), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, cnt;
    dir_t dx;

    Reset = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    Reset = 1'b0;
    repeat (2) step();

    // vSync held low for 20 cycles must yield exactly one tick.
    tick(0, 2, 2, FWD, FWD, 0, 20);

    pix(2, 2, 1'b1, 1'b1, 24'hFF_FF_00);
    pix(34, 2, 1'b1, 1'b0, 24'h00_00_80);
    pix(33, 33, 1'b1, 1'b1, 24'hFF_FF_00);
    pix(1, 2, 1'b1, 1'b0, 24'h00_00_80);
    pix(2, 34, 1'b1, 1'b1, 24'h00_00_80);
    pix(2, 2, 1'b0, 1'b1, 24'h00_00_00);
    step();
    blank_n_in = 1'b0;
    hSync_n_in = 1'b1;
    repeat (3) step();

    Pause = 1'b1;
    repeat (3) tick(0, 2, 2, FWD, FWD, 0, 1);
    Pause = 1'b0;
    tick(0, 4, 4, FWD, FWD, 0, 1);

    // STEP=5: X clamps at 768 on tick 154; Y never reaches its limit of 968.
    for (int i = 1; i <= 155; i++) begin
      if (i <= 153) begin x = 5 * i; dx = FWD; cnt = 0; end
      else if (i == 154) begin x = 768; dx = REV; cnt = 1; end
      else begin x = 763; dx = REV; cnt = 1; end
      tick(1, x, 5 * i, dx, FWD, cnt, 1);
    end

    // 64x64 display, STEP=4: both axes hit 32 together on tick 8.
    for (int i = 1; i <= 9; i++) begin
      if (i <= 7) tick(2, 4 * i, 4 * i, FWD, FWD, 0, 1);
      else if (i == 8) tick(2, 32, 32, REV, REV, 2, 1);
      else tick(2, 28, 28, REV, REV, 2, 1);
    end

    // Mid-line reset: pixel (2,2) is outside the (4,4) box but inside the reset (0,0) box.
    step();
    nextX = 11'd2;
    nextY = 10'd2;
    blank_n_in = 1'b1;
    hSync_n_in = 1'b0;
    Reset = 1'b1;
    step();
    check_reset_outputs("midreset");
    Reset = 1'b0;
    pq.push_back('{cyc + 1, 24'h00_00_00, 3'b011});
    pq.push_back('{cyc + 2, 24'hFF_FF_00, 3'b101});
    repeat (3) step();
    blank_n_in = 1'b0;
    hSync_n_in = 1'b1;
    repeat (2) step();
    tick(0, 2, 2, FWD, FWD, 0, 1);

    repeat (5) step();
    chk("a_ticks_outstanding", tq_a.size(), 0);
    chk("b_ticks_outstanding", tq_b.size(), 0);
    chk("c_ticks_outstanding", tq_c.size(), 0);
    chk("pix_outstanding", pq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
